// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types, widths and reset defaults for the fetch stage
package cpu_pkg;

    localparam int WORD = 32;

    localparam logic [WORD-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [WORD-1:0] NOP_INST_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } if_state_e;

    function automatic logic [WORD-1:0] word_align(input logic [WORD-1:0] a);
        return a & ~(WORD'(3));
    endfunction

endpackage

// File: rtl/cpu_if_skid.sv
// rtl/cpu_if_skid.sv - one-entry skid buffer catching a fetch that lands while ID is stalled
module cpu_if_skid
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_drain,
    input  logic            i_flush,
    input  logic [WORD-1:0] i_inst,
    input  logic [WORD-1:0] i_pc,
    output logic [WORD-1:0] o_inst,
    output logic [WORD-1:0] o_pc,
    output logic            o_valid
);

    logic [WORD-1:0] r_inst;
    logic [WORD-1:0] r_pc;
    logic            r_valid;

    // Flush beats load so a redirect in the same cycle never leaves a stale entry behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst  <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_inst  <= i_inst;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_inst  = r_inst;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/cpu_if.sv
// rtl/cpu_if.sv - instruction fetch stage: PC, imem request handshake, stall skid, redirect flush
module cpu_if
    import cpu_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [WORD-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_stall,
    input  logic            ex_redirect,
    input  logic [WORD-1:0] ex_target,
    output logic            im_req,
    output logic [WORD-1:0] im_addr,
    input  logic            im_ack,
    input  logic [WORD-1:0] im_rdata,
    output logic [WORD-1:0] if_pc,
    output logic [WORD-1:0] if_inst
);

    if_state_e       r_state;
    logic            r_im_req;
    logic [WORD-1:0] r_pc;
    logic [WORD-1:0] r_req_addr;
    logic [WORD-1:0] r_if_pc;
    logic [WORD-1:0] r_if_inst;

    if_state_e       w_next;
    logic            w_ack;
    logic [WORD-1:0] w_pc_inc;
    logic [WORD-1:0] w_target;
    logic            w_buf_load;
    logic            w_buf_drain;
    logic [WORD-1:0] w_buf_inst;
    logic [WORD-1:0] w_buf_pc;
    logic            w_buf_valid;

    assign w_ack    = r_im_req & im_ack;
    assign w_pc_inc = r_pc + WORD'(4);
    assign w_target = word_align(ex_target);

    // A redirect only needs KILL when a request is actually on the bus and unanswered.
    always_comb begin
        w_next      = r_state;
        w_buf_load  = 1'b0;
        w_buf_drain = 1'b0;
        if (ex_redirect) begin
            case (r_state)
                FETCH:   w_next = (r_im_req && !im_ack) ? KILL : FETCH;
                HOLD:    w_next = FETCH;
                KILL:    w_next = w_ack ? FETCH : KILL;
                default: w_next = FETCH;
            endcase
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_ack && id_stall) begin
                        w_next     = HOLD;
                        w_buf_load = 1'b1;
                    end
                end
                HOLD: begin
                    if (!id_stall) begin
                        w_next      = FETCH;
                        w_buf_drain = 1'b1;
                    end
                end
                KILL: begin
                    if (w_ack) w_next = FETCH;
                end
                default: w_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= FETCH;
            r_im_req   <= 1'b0;
            r_pc       <= word_align(RESET_PC);
            r_req_addr <= word_align(RESET_PC);
            r_if_pc    <= '0;
            r_if_inst  <= NOP_INST;
        end else begin
            r_state  <= w_next;
            r_im_req <= (w_next != HOLD);
            if (ex_redirect) begin
                r_pc      <= w_target;
                r_if_inst <= NOP_INST;
                if (w_next == FETCH) r_req_addr <= w_target;
            end else begin
                case (r_state)
                    FETCH: begin
                        if (w_ack) begin
                            r_pc       <= w_pc_inc;
                            r_req_addr <= w_pc_inc;
                            if (!id_stall) begin
                                r_if_inst <= im_rdata;
                                r_if_pc   <= r_req_addr;
                            end
                        end else if (!id_stall) begin
                            r_if_inst <= NOP_INST;
                        end
                    end
                    HOLD: begin
                        if (!id_stall && w_buf_valid) begin
                            r_if_inst <= w_buf_inst;
                            r_if_pc   <= w_buf_pc;
                        end
                    end
                    KILL: begin
                        r_if_inst <= NOP_INST;
                        if (w_ack) r_req_addr <= r_pc;
                    end
                    default: r_if_inst <= NOP_INST;
                endcase
            end
        end
    end

    cpu_if_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_buf_load),
        .i_drain (w_buf_drain),
        .i_flush (ex_redirect),
        .i_inst  (im_rdata),
        .i_pc    (r_req_addr),
        .o_inst  (w_buf_inst),
        .o_pc    (w_buf_pc),
        .o_valid (w_buf_valid)
    );

    assign im_req  = r_im_req;
    assign im_addr = r_req_addr;
    assign if_pc   = r_if_pc;
    assign if_inst = r_if_inst;

endmodule

// File: tb/tb_cpu_if.sv
// tb/tb_cpu_if.sv - scoreboard bench for cpu_if with a latency-programmable instruction memory
module tb_cpu_if;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        id_stall;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int          checks;
    int          failures;
    int          lat;
    logic        mem_en;
    int          wait_cnt;
    logic [63:0] exp_q[$];

    cpu_if #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .id_stall    (id_stall),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ack      (im_ack),
        .im_rdata    (im_rdata),
        .if_pc       (if_pc),
        .if_inst     (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        exp_q.push_back({a, a ^ KEY});
    endtask

    task automatic wait_addr(input logic [31:0] a, input string nm);
        int n;
        n = 0;
        while (!(im_req && im_addr == a) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 60) begin
            failures++;
            $display("FAIL %s timeout waiting for im_addr=%08h actual=%08h", nm, a, im_addr);
        end
    endtask

    // Memory: acks after lat cycles of a held request, returning addr^KEY.
    initial begin
        im_ack   = 1'b0;
        im_rdata = '0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (im_ack) wait_cnt = 0;
            if (!rst || !mem_en || !im_req) begin
                im_ack = 1'b0;
                if (!rst) wait_cnt = 0;
            end else if (wait_cnt >= lat - 1) begin
                im_ack   = 1'b1;
                im_rdata = im_addr ^ KEY;
            end else begin
                im_ack   = 1'b0;
                im_rdata = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end
    end

    // Monitor: every newly presented real instruction must be the next scoreboard entry.
    initial begin
        logic [31:0] prev_pc;
        logic [31:0] prev_inst;
        logic [63:0] e;
        prev_pc   = '0;
        prev_inst = NOP;
        forever begin
            @(negedge clk);
            if (if_inst != NOP && (if_inst != prev_inst || if_pc != prev_pc)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_unexpected actual pc=%08h inst=%08h required=none", if_pc, if_inst);
                end else begin
                    e = exp_q.pop_front();
                    if ({if_pc, if_inst} !== e) begin
                        failures++;
                        $display("FAIL stream actual pc=%08h inst=%08h required pc=%08h inst=%08h",
                                 if_pc, if_inst, e[63:32], e[31:0]);
                    end
                end
            end
            prev_pc   = if_pc;
            prev_inst = if_inst;
        end
    end

    // Handshake rules: aligned address, no change while a request is unanswered.
    initial begin
        logic        prev_req;
        logic        prev_ack;
        logic [31:0] prev_addr;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            #3;
            if (rst && im_req) begin
                chk("addr_align", {30'd0, im_addr[1:0]}, 32'd0);
                if (prev_req && !prev_ack) chk("addr_stable", im_addr, prev_addr);
            end
            prev_req  = rst & im_req;
            prev_ack  = im_ack;
            prev_addr = im_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b0;
        id_stall    = 1'b0;
        ex_redirect = 1'b0;
        ex_target   = '0;
        lat         = 1;
        mem_en      = 1'b1;

        #2;
        chk("reset_im_req", {31'd0, im_req}, 32'd0);
        chk("reset_if_pc", if_pc, 32'h0);
        chk("reset_if_inst", if_inst, NOP);
        chk("reset_im_addr", im_addr, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        chk("release_no_req_yet", {31'd0, im_req}, 32'd0);
        tick();
        chk("first_req", {31'd0, im_req}, 32'd1);
        chk("first_addr", im_addr, 32'h0);

        // Stall three cycles while the fetch of 8 completes.
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        wait_addr(32'h8, "wait_8");
        chk("stall_entry_pc", if_pc, 32'h4);
        id_stall = 1'b1;
        tick();
        chk("hold_req_low", {31'd0, im_req}, 32'd0);
        chk("hold_pc", if_pc, 32'h4);
        chk("hold_inst", if_inst, 32'h4 ^ KEY);
        chk("hold_buf_valid", {31'd0, u_dut.w_buf_valid}, 32'd1);
        tick();
        chk("hold2_req_low", {31'd0, im_req}, 32'd0);
        chk("hold2_pc", if_pc, 32'h4);
        tick();
        id_stall = 1'b0;
        tick();
        chk("drain_pc", if_pc, 32'h8);
        chk("drain_req_addr", im_addr, 32'hC);

        // Three-cycle memory latency on the fetch of 16.
        push(32'h10); push(32'h14); push(32'h18); push(32'h1C);
        wait_addr(32'h10, "wait_10");
        lat = 3;
        chk("lat_c0_inst", if_inst, 32'hC ^ KEY);
        tick();
        chk("lat_c1_addr", im_addr, 32'h10);
        chk("lat_c1_inst", if_inst, NOP);
        tick();
        chk("lat_c2_addr", im_addr, 32'h10);
        chk("lat_c2_inst", if_inst, NOP);
        tick();
        chk("lat_data_pc", if_pc, 32'h10);
        chk("lat_data_inst", if_inst, 32'h10 ^ KEY);
        lat = 2;

        // Redirect while the request to 0x20 is outstanding.
        push(32'h100);
        wait_addr(32'h20, "wait_20");
        ex_redirect = 1'b1;
        ex_target   = 32'h103;
        tick();
        ex_redirect = 1'b0;
        chk("kill_req", {31'd0, im_req}, 32'd1);
        chk("kill_stale_addr", im_addr, 32'h20);
        chk("kill_inst_nop", if_inst, NOP);
        tick();
        chk("kill_refetch_addr", im_addr, 32'h100);
        chk("kill_after_inst_nop", if_inst, NOP);
        lat = 1;
        tick();
        chk("target_pc", if_pc, 32'h100);

        // Redirect with stall active and the skid holding 0x104.
        push(32'h200);
        id_stall = 1'b1;
        tick();
        chk("skid_full", {31'd0, u_dut.w_buf_valid}, 32'd1);
        chk("skid_req_low", {31'd0, im_req}, 32'd0);
        ex_redirect = 1'b1;
        ex_target   = 32'h200;
        tick();
        ex_redirect = 1'b0;
        id_stall    = 1'b0;
        chk("flush_inst_nop", if_inst, NOP);
        chk("flush_pc_kept", if_pc, 32'h100);
        chk("flush_buf_clear", {31'd0, u_dut.w_buf_valid}, 32'd0);
        chk("flush_req_addr", im_addr, 32'h200);
        tick();
        chk("flush_target_pc", if_pc, 32'h200);

        // Asynchronous reset in the middle of a slow handshake.
        lat = 3;
        tick();
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, im_req}, 32'd0);
        chk("async_rst_pc", if_pc, 32'h0);
        chk("async_rst_inst", if_inst, NOP);
        chk("async_rst_addr", im_addr, 32'h0);
        tick();
        tick();
        lat = 1;
        push(32'h0); push(32'h4); push(32'h8);
        rst = 1'b1;
        tick();
        chk("restart_req", {31'd0, im_req}, 32'd1);
        chk("restart_addr", im_addr, 32'h0);
        wait_addr(32'hC, "wait_restart_c");
        mem_en = 1'b0;
        repeat (4) tick();
        chk("final_pc", if_pc, 32'h8);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
